prga: RTL and testbench
=======================

PRGA -- requirements
Module: prga

Interface
REQ-001 SHALL have parameter none; all widths fixed (S size 256, byte data).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  start request; honoured only when rdy=1.
REQ-005 rdy  output  1  high when idle and able to accept en.
REQ-006 s_addr / s_wrdata  output  8 each  S memory address / write data.
REQ-007 s_rddata  input  8  S memory read data, valid cycle after address.
REQ-008 s_wren  output  1  S memory write strobe.
REQ-009 ct_addr  output  8  ciphertext memory address; ct_rddata  input  8  read data, one-cycle latency.
REQ-010 pt_addr / pt_wrdata  output  8 each; pt_wren  output  1  plaintext memory write port.

Function
REQ-011 Memory model: synchronous read; address driven in cycle N gives rddata in cycle N+1; write commits at edge ending the cycle with wren=1.
REQ-012 Message format: ct[0]=length L (0..255); ct[1..L] ciphertext; pt[0] SHALL receive L, pt[1..L] plaintext.
REQ-013 Per byte k=1..L: i=(i+1) mod 256; j=(j+S[i]) mod 256; swap S[i],S[j]; pt[k]=S[(S[i]+S[j]) mod 256] XOR ct[k]; i,j start at 0.
REQ-014 States: IDLE, LEN_RD, LEN_CAP, I_RD, I_CAP, J_RD, J_CAP, W_I, W_J, PAD_RD, PT_WR.
REQ-015 IDLE: rdy=1; en=1 -> LEN_RD, rdy=0 next cycle.
REQ-016 LEN_RD: ct_addr=0. LEN_CAP: latch L=ct_rddata; pt_addr=0, pt_wrdata=L, pt_wren=1; i=j=0, k=1; L=0 -> IDLE else -> I_RD.
REQ-017 I_RD: i<=i+1, s_addr=i+1. I_CAP: si<=s_rddata, j<=j+s_rddata.
REQ-018 J_RD: s_addr=j. J_CAP: sj<=s_rddata; ct_addr=k.
REQ-019 W_I: s_addr=i, s_wrdata=sj, s_wren=1; latch ctk=ct_rddata. W_J: s_addr=j, s_wrdata=si, s_wren=1.
REQ-020 PAD_RD: s_addr=(si+sj) mod 256. PT_WR: pt_addr=k, pt_wrdata=s_rddata XOR ctk, pt_wren=1; k==L -> IDLE else k<=k+1 -> I_RD.
REQ-021 Busy duration: rdy low exactly 2+8L cycles after en accepted.
REQ-022 i==j: swap SHALL write the same value twice; result identical to no swap.
REQ-023 All index sums SHALL wrap modulo 256 (8-bit truncation); k SHALL never overflow (compare before increment).
REQ-024 en while rdy=0 SHALL be ignored; en held high in IDLE after completion starts a new run.
REQ-025 Outside their write states s_wren and pt_wren SHALL be 0; unused addresses/wrdata drive 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, rdy=1, all wren=0, addresses/data=0, i=j=k=L=si=sj=ctk=0.
REQ-027 Reset mid-run SHALL abort; memory contents already written are not restored.

Structure
REQ-028 State enum and constants (MSG_LEN_ADDR=0, S_SIZE=256) SHALL live in shared package arc4_pkg, also used by init and ksa.
REQ-029 Single flat module; no sub-module needed; arbitration of shared S memory remains in the top level.

Verification
REQ-030 S identity (S[x]=x), ct[0]=0: en -> pt[0]=0, rdy low exactly 2 cycles, no s_wren.
REQ-031 S identity, ct={1,0x41}: pt[0]=1, pt[1]=0x43, rdy low exactly 10 cycles.
REQ-032 S identity, ct={2,0x41,0x00}: pt[1]=0x43, pt[2]=0x05; S[2]=3, S[3]=2 afterwards.
REQ-033 S from ksa with key 0x000018, L=255 random ct: pt matches software ARC4 model byte-for-byte; i,j wrap correctly.
REQ-034 Pulse rst_n low during byte 3 of L=10 run: rdy=1 and wrens=0 asynchronously; fresh en completes correctly after S reload.
REQ-035 Hold en high throughout a run: exactly one run per rdy=1 IDLE cycle; no restart while busy.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 constants, state encoding and index arithmetic
package arc4_pkg;

    localparam logic [7:0] MSG_LEN_ADDR = 8'd0;
    localparam int         S_SIZE       = 256;

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_CAP,
        I_RD,
        I_CAP,
        J_RD,
        J_CAP,
        W_I,
        W_J,
        PAD_RD,
        PT_WR
    } prga_state_t;

    // Index arithmetic is always modulo S_SIZE, i.e. plain 8-bit truncation.
    function automatic logic [7:0] idx_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/prga_if.sv
// rtl/prga_if.sv - start handshake plus S, ciphertext and plaintext memory ports
interface prga_if;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_wrdata;
    logic [7:0] s_rddata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface

// File: rtl/prga.sv
// rtl/prga.sv - ARC4 keystream generator decrypting ct memory into pt memory
module prga
    import arc4_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    prga_if.master  bus
);

    prga_state_t state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [7:0]  ctk_q, ctk_d;

    logic        rdy;
    logic [7:0]  s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
    logic        s_wren, pt_wren;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            len_q   <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            ctk_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            ctk_q   <= ctk_d;
        end
    end

    // Outputs decode purely from state so the async reset clears them at once.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        ctk_d     = ctk_q;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.en) state_d = LEN_RD;
            end
            LEN_RD: begin
                ct_addr = MSG_LEN_ADDR;
                state_d = LEN_CAP;
            end
            LEN_CAP: begin
                len_d     = bus.ct_rddata;
                pt_addr   = MSG_LEN_ADDR;
                pt_wrdata = bus.ct_rddata;
                pt_wren   = 1'b1;
                i_d       = 8'd0;
                j_d       = 8'd0;
                k_d       = 8'd1;
                state_d   = (bus.ct_rddata == 8'd0) ? IDLE : I_RD;
            end
            I_RD: begin
                i_d     = idx_add(i_q, 8'd1);
                s_addr  = idx_add(i_q, 8'd1);
                state_d = I_CAP;
            end
            I_CAP: begin
                si_d    = bus.s_rddata;
                j_d     = idx_add(j_q, bus.s_rddata);
                state_d = J_RD;
            end
            J_RD: begin
                s_addr  = j_q;
                state_d = J_CAP;
            end
            J_CAP: begin
                sj_d    = bus.s_rddata;
                ct_addr = k_q;
                state_d = W_I;
            end
            W_I: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                ctk_d    = bus.ct_rddata;
                state_d  = W_J;
            end
            W_J: begin
                // When i==j this rewrites the value W_I just stored, leaving S unchanged.
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = PAD_RD;
            end
            PAD_RD: begin
                s_addr  = idx_add(si_q, sj_q);
                state_d = PT_WR;
            end
            PT_WR: begin
                pt_addr   = k_q;
                pt_wrdata = bus.s_rddata ^ ctk_q;
                pt_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d     = idx_add(k_q, 8'd1);
                    state_d = I_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdy       = rdy;
    assign bus.s_addr    = s_addr;
    assign bus.s_wrdata  = s_wrdata;
    assign bus.s_wren    = s_wren;
    assign bus.ct_addr   = ct_addr;
    assign bus.pt_addr   = pt_addr;
    assign bus.pt_wrdata = pt_wrdata;
    assign bus.pt_wren   = pt_wren;

endmodule

// File: tb/tb_prga.sv
// tb/tb_prga.sv - scoreboard bench for prga against hand vectors and an ARC4 model
module tb_prga;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prga_if bus();

    prga u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic [7:0] sw_s   [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic       load_s = 1'b0;

    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int swren_cnt = 0;
    int ptwr_cnt = 0;

    always @(posedge clk) begin
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.ct_rddata <= ct_mem[bus.ct_addr];
        if (load_s) s_mem <= s_init;
        else if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
        if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.s_wren) swren_cnt++;
        if (rst_n && bus.pt_wren) begin
            ptwr_cnt++;
            if (exp_q.size() == 0) begin
                check("pt_unexpected_write", {16'd0, bus.pt_addr, bus.pt_wrdata}, 32'hffff_ffff);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check($sformatf("pt_write[%0d]", e[15:8]), {16'd0, bus.pt_addr, bus.pt_wrdata}, {16'd0, e});
            end
        end
    end

    task automatic set_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic set_ksa();
        logic [7:0] key [3];
        logic [7:0] j, t;
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
        set_identity();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + s_init[x] + key[x % 3];
            t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        sw_s = s_init;
    endtask

    task automatic model_push(input int len);
        logic [7:0] i, j, t, ks;
        exp_q.push_back({8'd0, 8'(len)});
        i = 8'd0; j = 8'd0;
        for (int k = 1; k <= len; k++) begin
            i = i + 8'd1;
            j = j + sw_s[i];
            t = sw_s[i]; sw_s[i] = sw_s[j]; sw_s[j] = t;
            ks = sw_s[8'(sw_s[i] + sw_s[j])];
            exp_q.push_back({8'(k), ks ^ ct_mem[k]});
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!bus.rdy && t < 5000) begin @(negedge clk); t++; end
        if (!bus.rdy) check("idle_timeout", 0, 1);
    endtask

    task automatic run_msg(output int busy);
        wait_idle();
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        busy = 0;
        @(negedge clk);
        while (!bus.rdy && busy < 5000) begin busy++; @(negedge clk); end
    endtask

    task automatic check_s_final(input string name);
        int mism = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== sw_s[x]) mism++;
        check(name, mism, 0);
    endtask

    int busy, base, starts;

    initial begin
        bus.en = 1'b0;
        for (int x = 0; x < 256; x++) begin ct_mem[x] = 8'd0; pt_mem[x] = 8'd0; end
        set_identity();
        s_mem = s_init;
        #12;
        check("reset_rdy", bus.rdy, 1);
        check("reset_wrens", {bus.s_wren, bus.pt_wren}, 0);
        check("reset_addrs", {bus.s_addr, bus.ct_addr, bus.pt_addr, bus.pt_wrdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // L=0: only the length byte is written, no S traffic
        ct_mem[0] = 8'd0;
        exp_q.push_back(16'h0000);
        base = swren_cnt;
        run_msg(busy);
        check("busy_l0", busy, 2);
        check("swren_l0", swren_cnt - base, 0);

        // L=1, identity S
        ct_mem[0] = 8'd1; ct_mem[1] = 8'h41;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0143);
        run_msg(busy);
        check("busy_l1", busy, 10);

        // L=2, identity S reloaded; second byte swaps S[2], S[3]
        set_identity();
        load_mem();
        ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0143);
        exp_q.push_back(16'h0205);
        run_msg(busy);
        check("busy_l2", busy, 18);
        check("s2_after", s_mem[2], 3);
        check("s3_after", s_mem[3], 2);

        // L=255 with KSA-scheduled S, exercises i and j wrap
        set_ksa();
        load_mem();
        ct_mem[0] = 8'd255;
        for (int k = 1; k < 256; k++) ct_mem[k] = 8'((k * 37 + 11) & 255);
        model_push(255);
        run_msg(busy);
        check("busy_l255", busy, 2 + 8 * 255);
        check_s_final("s_final_l255");
        check("pt255_mem", pt_mem[255], 32'(exp_last_pt()));

        // Reset during byte 3 of an L=10 run, then a clean rerun
        set_ksa();
        load_mem();
        ct_mem[0] = 8'd10;
        model_push(10);
        base = ptwr_cnt;
        wait_idle();
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        #1 bus.en = 1'b0;
        for (int t = 0; t < 200 && (ptwr_cnt - base) < 3; t++) @(negedge clk);
        check("pre_reset_writes", ptwr_cnt - base, 3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rdy", bus.rdy, 1);
        check("abort_wrens", {bus.s_wren, bus.pt_wren}, 0);
        check("abort_addrs", {bus.s_addr, bus.s_wrdata, bus.ct_addr, bus.pt_addr}, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_ksa();
        load_mem();
        model_push(10);
        run_msg(busy);
        check("busy_rerun", busy, 82);
        check_s_final("s_final_rerun");

        // en held high: back-to-back L=0 runs, one start per idle cycle
        wait_idle();
        ct_mem[0] = 8'd0;
        for (int r = 0; r < 10; r++) exp_q.push_back(16'h0000);
        base = ptwr_cnt;
        starts = 0;
        @(negedge clk);
        bus.en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.rdy) starts++;
            @(negedge clk);
        end
        bus.en = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_starts", starts, 10);
        check("hold_pt_writes", ptwr_cnt - base, 10);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [7:0] exp_last_pt();
        logic [7:0] s [256];
        logic [7:0] i, j, t, b;
        set_ksa_into(s);
        i = 8'd0; j = 8'd0; b = 8'd0;
        for (int k = 1; k <= 255; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            b = s[8'(s[i] + s[j])] ^ ct_mem[k];
        end
        return b;
    endfunction

    function automatic void set_ksa_into(output logic [7:0] s [256]);
        logic [7:0] j, t;
        logic [7:0] key [3];
        key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + s[x] + key[x % 3];
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
    endfunction

endmodule
